// File: rtl/cls_pkg.sv
// Shared constants for the SPI byte transmitter: default timing, FIFO depth and FSM encoding.
package cls_pkg;

  localparam int CLK_DIV_DEF    = 50;
  localparam int GAP_CYCLES_DEF = 4000;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SETUP    = 3'd1;
  localparam state_t ST_SHIFT_LO = 3'd2;
  localparam state_t ST_SHIFT_HI = 3'd3;
  localparam state_t ST_HOLD     = 3'd4;
  localparam state_t ST_GAP      = 3'd5;

endpackage

// File: rtl/cls_byte_fifo.sv
// Circular byte FIFO with a separately tracked count; full writes are dropped.
module cls_byte_fifo
  import cls_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
);

  localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_r [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == DEPTH);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && (|count_r);

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count changes only on push xor pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cls_spi_tx.sv
// SPI mode-0 byte transmitter fed from a FIFO; one byte per slave-select window, with a fixed SS-high gap.
module cls_spi_tx
  import cls_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wr_valid,
  input  logic [7:0]          wr_data,
  output logic                wr_ready,
  output logic                ss,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [7:0]          rx_data,
  output logic                byte_done,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_count
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_r;
  logic [15:0] div_r;
  logic [2:0]  bit_r;
  logic [6:0]  tx_sh_r;
  logic [7:0]  rx_sh_r;
  logic        ss_r;
  logic        sclk_r;
  logic        mosi_r;
  logic        byte_done_r;
  logic [7:0]  rx_data_r;

  logic        pop_s;
  logic        full_s;
  logic        div_end_s;
  logic [7:0]  pop_data_s;
  logic [DEPTH_LOG2:0] count_s;

  cls_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (count_s),
    .full      (full_s)
  );

  assign pop_s      = (state_r == ST_IDLE) && (|count_s);
  assign wr_ready   = !full_s;
  assign fifo_count = count_s;
  assign busy       = (state_r != ST_IDLE) || (|count_s);
  assign ss         = ss_r;
  assign sclk       = sclk_r;
  assign mosi       = mosi_r;
  assign rx_data    = rx_data_r;
  assign byte_done  = byte_done_r;

  // Terminal count of the shared divider: GAP uses its own, longer limit.
  always_comb begin
    div_end_s = 1'b0;
    if (state_r == ST_GAP) begin
      div_end_s = (div_r == GAP_LAST);
    end else begin
      div_end_s = (div_r == DIV_LAST);
    end
  end

  // Byte FSM: 8 high/low sclk pairs framed by SETUP and HOLD; the last low phase keeps bit0 on mosi.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      div_r       <= 16'd0;
      bit_r       <= 3'd0;
      tx_sh_r     <= 7'd0;
      rx_sh_r     <= 8'd0;
      ss_r        <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      byte_done_r <= 1'b0;
      rx_data_r   <= 8'd0;
    end else begin
      byte_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          div_r <= 16'd0;
          if (pop_s) begin
            tx_sh_r <= pop_data_s[6:0];
            mosi_r  <= pop_data_s[7];
            ss_r    <= 1'b0;
            bit_r   <= 3'd0;
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_end_s) begin
            div_r   <= 16'd0;
            sclk_r  <= 1'b1;
            rx_sh_r <= {rx_sh_r[6:0], miso};
            state_r <= ST_SHIFT_HI;
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        ST_SHIFT_HI: begin
          if (div_end_s) begin
            div_r   <= 16'd0;
            sclk_r  <= 1'b0;
            state_r <= ST_SHIFT_LO;
            if (bit_r != 3'd7) begin
              mosi_r  <= tx_sh_r[6];
              tx_sh_r <= {tx_sh_r[5:0], 1'b0};
            end
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        ST_SHIFT_LO: begin
          if (div_end_s) begin
            div_r <= 16'd0;
            if (bit_r == 3'd7) begin
              state_r <= ST_HOLD;
            end else begin
              bit_r   <= bit_r + 3'd1;
              sclk_r  <= 1'b1;
              rx_sh_r <= {rx_sh_r[6:0], miso};
              state_r <= ST_SHIFT_HI;
            end
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        ST_HOLD: begin
          if (div_end_s) begin
            div_r       <= 16'd0;
            ss_r        <= 1'b1;
            byte_done_r <= 1'b1;
            rx_data_r   <= rx_sh_r;
            state_r     <= ST_GAP;
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (div_end_s) begin
            div_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          div_r   <= 16'd0;
          ss_r    <= 1'b1;
          sclk_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cls_spi_tx.md
CLS_SPI_TX -- requirements
Module: cls_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, CLK cycles per SCLK half-period (100 MHz -> 1 MHz SCLK); legal range 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4000, CLK cycles SS stays high between bytes; legal range 1..65535.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth 2**DEPTH_LOG2 bytes.
REQ-004 CLK  input  1  system clock, all logic on rising edge; one clock domain only.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 wr_valid  input  1  producer offers wr_data this cycle.
REQ-007 wr_data  input  8  byte to transmit (ASCII or command byte).
REQ-008 wr_ready  output  1  FIFO not full; a byte is accepted on any edge where wr_valid and wr_ready are both high.
REQ-009 ss  output  1  slave select, active low.
REQ-010 sclk  output  1  SPI clock, mode 0, idles low.
REQ-011 mosi  output  1  serial data, MSB first.
REQ-012 miso  input  1  serial data from slave, sampled on SCLK rising edge.
REQ-013 rx_data  output  8  last byte shifted in from miso.
REQ-014 byte_done  output  1  one-cycle pulse when a byte completes (SS deasserts).
REQ-015 busy  output  1  high whenever the state is not IDLE or the FIFO is non-empty.
REQ-016 fifo_count  output  DEPTH_LOG2+1  number of bytes stored, 0..2**DEPTH_LOG2.

Function
REQ-017 FIFO SHALL be circular, with wr_ptr and rd_ptr wrapping modulo depth, and count tracked separately; wr_ready SHALL equal (count != depth), driven from registered count only (no same-cycle bypass).
REQ-018 A write while full SHALL be ignored, leaving count and data unchanged; a simultaneous write and pop SHALL leave count unchanged.
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP; a single divider counter, 0..CLK_DIV-1 (or 0..GAP_CYCLES-1 in GAP), SHALL time every state.
REQ-020 IDLE: when count>0, the FSM SHALL pop one byte into the shift register, drive ss low, drive mosi to bit7, and enter SETUP; a byte written into an empty FIFO SHALL start no earlier than the following edge.
REQ-021 SETUP SHALL last CLK_DIV cycles with sclk low, then enter SHIFT_HI.
REQ-022 SHIFT_HI SHALL last CLK_DIV cycles with sclk high; on entry miso SHALL be sampled into the rx shift register.
REQ-023 SHIFT_LO SHALL last CLK_DIV cycles with sclk low; on entry mosi SHALL advance to the next bit; after bit0 has had its high phase the FSM SHALL enter HOLD instead.
REQ-024 HOLD SHALL last CLK_DIV cycles with sclk low and ss low, then drive ss high, pulse byte_done, load rx_data, and enter GAP.
REQ-025 GAP SHALL last GAP_CYCLES cycles with ss high, then enter IDLE.
REQ-026 Byte period SHALL be exactly 1 (IDLE pop) + CLK_DIV*(1+16+1) + GAP_CYCLES cycles when the FIFO stays non-empty; bytes SHALL be transmitted in write order.
REQ-027 sclk, ss and mosi SHALL be driven directly from flip-flops (glitch-free).
REQ-028 SCLK SHALL pulse exactly 8 times per byte, and only while ss is low.

Reset
REQ-029 On RST: state=IDLE, ss=1, sclk=0, mosi=0, byte_done=0, rx_data=0, pointers=0, count=0, busy=0, wr_ready=1, all from the next edge.
REQ-030 RST asserted mid-byte SHALL abort the transfer, discard all FIFO contents, and produce no byte_done.
REQ-031 RST SHALL take priority over wr_valid on the same edge.

Structure
REQ-032 The state encoding and the default CLK_DIV, GAP_CYCLES and DEPTH_LOG2 values SHALL live in the shared package cls_pkg.
REQ-033 The FIFO SHALL be a sub-module cls_byte_fifo (push/pop/count); the FSM and shifter SHALL sit in cls_spi_tx.

Verification (CLK_DIV=2, GAP_CYCLES=4, DEPTH_LOG2=2 unless stated)
REQ-034 Write 0xA5 while idle, miso tied to 1 -> ss low for 36 cycles; mosi at the 8 sclk rises reads 1,0,1,0,0,1,0,1; then byte_done pulses once and rx_data=0xFF.
REQ-035 Write 0x1B,0x5B,0x6A back-to-back -> the three bytes appear in order; ss-low windows start 41 cycles apart; fifo_count goes 1,2,3 then decrements per pop.
REQ-036 Write 6 bytes with wr_valid held high -> 4 accepted (plus 1 per pop during streaming); wr_ready low while count=4; no dropped or duplicated bytes; pointers wrap correctly.
REQ-037 Hold wr_valid high while full and popping -> count holds at 4 for the blocked cycle, with no overwrite of unread data.
REQ-038 Assert RST for 1 cycle during the 4th sclk high -> next edge ss=1, sclk=0, mosi=0, count=0, no byte_done; a subsequent write of 0x7C transmits cleanly.
REQ-039 Defaults (CLK_DIV=50, GAP_CYCLES=4000), write 0x41 -> sclk period 100 CLK cycles (1 MHz), ss-high gap of 4000 cycles before next IDLE.
